// File: rtl/tdc_pkg.sv
// rtl/tdc_pkg.sv - shared constants, timestamp word layout and fine-code check for the TDC packer
//
// Purpose: word geometry of the TDC timestamp FIFO and the delay-line tap count,
// shared by the packer, its buffer and the bench.
// Ports: none (package).
package tdc_pkg;

   localparam int DATA_WIDTH   = 64;
   localparam int COARSE_WIDTH = 56;
   localparam int FINE_WIDTH   = 8;
   localparam int NTAPS        = 192;

   typedef struct packed {
      logic [COARSE_WIDTH-1:0] coarse;
      logic [FINE_WIDTH-1:0]   fine;
   } tdc_word_t;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_PRESENT = 1'b1
   } pres_state_t;

   // A fine code addresses a delay-line tap, so anything at or past NTAPS is bogus.
   function automatic logic fine_valid(input logic [FINE_WIDTH-1:0] fine);
      return (32'(fine) < 32'(NTAPS));
   endfunction

endpackage

// File: rtl/tdc_sync_buf.sv
// rtl/tdc_sync_buf.sv - small register FIFO holding captured words ahead of the stream output
//
// Purpose: DEPTH x WIDTH register FIFO. The head entry stays in place while it is
// presented downstream and is only removed by pop_i.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   push_i         write push_data_i at the tail
//   push_data_i    entry to store
//   pop_i          drop the head entry
//   head_o         entry at the read pointer
//   next_o         entry behind the head (valid when occ_o >= 2)
//   occ_o          number of stored entries
module tdc_sync_buf
   import tdc_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = DATA_WIDTH + 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         push_data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         head_o,
   output logic [WIDTH-1:0]         next_o,
   output logic [$clog2(DEPTH):0]   occ_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0]  mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q;
   logic [AW-1:0]     rd_ptr_q;
   logic [AW-1:0]     rd_ptr_nxt;
   logic [AW:0]       occ_q;
   logic [AW:0]       occ_d;

   // DEPTH is a power of two, so the pointers wrap on their own.
   assign rd_ptr_nxt = rd_ptr_q + 1'b1;
   assign head_o     = mem_q[rd_ptr_q];
   assign next_o     = mem_q[rd_ptr_nxt];
   assign occ_o      = occ_q;

   always_comb begin
      occ_d = occ_q;
      case ({push_i, pop_i})
         2'b10:   occ_d = occ_q + 1'b1;
         2'b01:   occ_d = occ_q - 1'b1;
         default: occ_d = occ_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (pop_i) begin
            rd_ptr_q <= rd_ptr_nxt;
         end
         occ_q <= occ_d;
      end
   end

endmodule

// File: rtl/tdc_fifo_axis_packer.sv
// rtl/tdc_fifo_axis_packer.sv - drains the TDC timestamp FIFO into framed AXI-Stream packets
//
// Purpose: reads the channel FIFO under a credit limit, tags out-of-range fine
// codes, and frames words into PKT_LEN-beat packets. A partial packet is closed
// after TIMEOUT idle cycles or when enable drops.
// Ports:
//   clk, rst_n        clock (FIFO read clock), asynchronous active-low reset
//   enable            allow FIFO reads; low flushes the open packet
//   fifo_dout         FIFO read data, valid one cycle after fifo_rd_en
//   fifo_empty        FIFO empty flag
//   fifo_rd_en        FIFO read strobe
//   m_axis_tdata/tvalid/tready/tlast  stream master
//   m_axis_tuser      fine code >= NTAPS on this beat
//   pkt_count         completed packets (wraps)
//   err_count         invalid fine codes captured (saturates)
//   busy              buffer non-empty, read in flight, or beat presented
//
// A reset in the middle of a packet drops it without a tlast beat; the DMA
// downstream has to resynchronise on the next packet.
module tdc_fifo_axis_packer
   import tdc_pkg::*;
#(
   parameter int PKT_LEN   = 256,
   parameter int TIMEOUT   = 4096,
   parameter int BUF_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic [DATA_WIDTH-1:0] fifo_dout,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic                  m_axis_tuser,
   output logic [31:0]           pkt_count,
   output logic [15:0]           err_count,
   output logic                  busy
);

   localparam int OW = $clog2(BUF_DEPTH) + 1;
   localparam int BW = $clog2(PKT_LEN);
   localparam int TW = $clog2(TIMEOUT);
   localparam logic [BW-1:0] BEAT_LAST = BW'(PKT_LEN - 1);
   localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 1);
   localparam logic [OW-1:0] OCC_ONE   = OW'(1);
   localparam logic [OW-1:0] OCC_TWO   = OW'(2);
   localparam logic [OW-1:0] OCC_FULL  = OW'(BUF_DEPTH);

   pres_state_t           state_q;
   logic                  inflight_q;
   logic [DATA_WIDTH-1:0] tdata_q;
   logic                  tuser_q;
   logic                  tlast_q;
   logic [BW-1:0]         beat_q;
   logic [TW-1:0]         timer_q;
   logic [31:0]           pkt_q;
   logic [15:0]           err_q;

   logic [OW-1:0]         occ;
   logic [DATA_WIDTH:0]   head;
   logic [DATA_WIDTH:0]   nxt;
   logic                  cap_user;
   logic                  hs;
   logic [BW-1:0]         beat_next;
   logic [OW-1:0]         occ_after;
   logic                  present;
   logic                  pres_last;
   logic [DATA_WIDTH:0]   pres_entry;

   // Credit counts the word still on the FIFO bus, so the buffer cannot overflow.
   // rst_n is folded in so the strobe drops together with the async reset.
   assign fifo_rd_en = rst_n && enable && !fifo_empty &&
                       ((occ + OW'(inflight_q)) < OCC_FULL);

   assign cap_user  = !fine_valid(fifo_dout[FINE_WIDTH-1:0]);
   assign hs        = (state_q == ST_PRESENT) && m_axis_tready;
   assign beat_next = tlast_q ? '0 : beat_q + 1'b1;
   // Entries left behind the beat being accepted, including this cycle's capture.
   assign occ_after = occ - OCC_ONE + OW'(inflight_q);

   tdc_sync_buf #(
      .DEPTH (BUF_DEPTH),
      .WIDTH (DATA_WIDTH + 1)
   ) u_buf (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (inflight_q),
      .push_data_i ({cap_user, fifo_dout}),
      .pop_i       (hs),
      .head_o      (head),
      .next_o      (nxt),
      .occ_o       (occ)
   );

   // The last buffered word is held back until we know whether it closes the
   // packet (more data behind it, full packet, idle timeout or flush). On a
   // handshake the following entry is presented straight away when it is
   // already known not to need that decision, which keeps one beat per cycle.
   always_comb begin
      present    = 1'b0;
      pres_last  = 1'b0;
      pres_entry = head;
      if (state_q == ST_IDLE) begin
         if (occ >= OCC_TWO) begin
            present   = 1'b1;
            pres_last = (beat_q == BEAT_LAST);
         end else if (occ == OCC_ONE) begin
            if (beat_q == BEAT_LAST) begin
               present   = 1'b1;
               pres_last = 1'b1;
            end else if (!inflight_q &&
                         ((fifo_empty && timer_q == TIMER_MAX) || !enable)) begin
               present   = 1'b1;
               pres_last = 1'b1;
            end
         end
      end else if (hs) begin
         pres_entry = nxt;
         if (occ_after >= OCC_TWO) begin
            present   = 1'b1;
            pres_last = (beat_next == BEAT_LAST);
         end else if (occ >= OCC_TWO && beat_next == BEAT_LAST) begin
            present   = 1'b1;
            pres_last = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         inflight_q <= 1'b0;
         tdata_q    <= '0;
         tuser_q    <= 1'b0;
         tlast_q    <= 1'b0;
         beat_q     <= '0;
         timer_q    <= '0;
         pkt_q      <= '0;
         err_q      <= '0;
      end else begin
         inflight_q <= fifo_rd_en;

         case (state_q)
            ST_IDLE: begin
               if (present) begin
                  state_q <= ST_PRESENT;
                  tdata_q <= pres_entry[DATA_WIDTH-1:0];
                  tuser_q <= pres_entry[DATA_WIDTH];
                  tlast_q <= pres_last;
               end
            end
            ST_PRESENT: begin
               if (hs) begin
                  beat_q <= beat_next;
                  if (tlast_q) begin
                     pkt_q <= pkt_q + 1'b1;
                  end
                  if (present) begin
                     tdata_q <= pres_entry[DATA_WIDTH-1:0];
                     tuser_q <= pres_entry[DATA_WIDTH];
                     tlast_q <= pres_last;
                  end else begin
                     state_q <= ST_IDLE;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase

         if (inflight_q && cap_user && err_q != 16'hFFFF) begin
            err_q <= err_q + 1'b1;
         end

         if (inflight_q || hs) begin
            timer_q <= '0;
         end else if (occ == OCC_ONE && state_q == ST_IDLE && timer_q != TIMER_MAX) begin
            timer_q <= timer_q + 1'b1;
         end
      end
   end

   assign m_axis_tdata  = tdata_q;
   assign m_axis_tvalid = (state_q == ST_PRESENT);
   assign m_axis_tlast  = tlast_q;
   assign m_axis_tuser  = tuser_q;
   assign pkt_count     = pkt_q;
   assign err_count     = err_q;
   assign busy          = (occ != '0) || inflight_q || (state_q == ST_PRESENT);

endmodule

// File: doc/tdc_fifo_axis_packer.md
Name: tdc_fifo_axis_packer

Overview:
- Downstream stage of a TDC channel: drains the channel's 64-bit timestamp FIFO and emits AXI-Stream packets to the DMA path.
- FIFO word format: {coarse[COARSE_WIDTH-1:0], fine[FINE_WIDTH-1:0]}.
- Each word is framed into packets of PKT_LEN beats. Partial packets are closed on an idle timeout.
- Fine codes that are out of range are flagged in tuser and counted.

Parameters:
- DATA_WIDTH, 64, FIFO and stream word width.
- COARSE_WIDTH, 56, coarse-count field width (upper bits).
- FINE_WIDTH, 8, fine-code field width (lower bits); COARSE_WIDTH+FINE_WIDTH = DATA_WIDTH.
- NTAPS, 192, number of delay-line taps; a valid fine code is < NTAPS.
- PKT_LEN, 256, beats per full packet (>= 2).
- TIMEOUT, 4096, idle cycles before a partial packet is closed.
- BUF_DEPTH, 4, internal buffer entries (power of 2, >= 2).

Ports:
- clk  in  1  single clock, same as the FIFO read clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  allow FIFO reads; deasserting it flushes the open packet.
- fifo_dout  in  DATA_WIDTH  FIFO read data, valid 1 cycle after fifo_rd_en (standard mode, not FWFT).
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  FIFO read strobe.
- m_axis_tdata  out  DATA_WIDTH  stream data.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.
- m_axis_tlast  out  1  last beat of packet.
- m_axis_tuser  out  1  fine code >= NTAPS on this beat.
- pkt_count  out  32  packets completed (wraps).
- err_count  out  16  invalid fine codes seen (saturates at 0xFFFF).
- busy  out  1  buffer non-empty, or a read in flight, or a beat presented.

Behaviour:
- Reset (async assert, sync release): all outputs 0, counters 0, buffer empty, timer 0, beat index 0.
- Read side:
  - fifo_rd_en = enable && !fifo_empty && (occ + inflight < BUF_DEPTH).
  - inflight is 1 in the cycle after fifo_rd_en.
  - fifo_dout is captured into the buffer in that cycle.
  - The credit rule means the buffer never overflows; throughput is 1 word/cycle when m_axis_tready is held high.
- Capture: tuser bit = (fine >= NTAPS). err_count increments on capture, not on output.
- Presentation rule, evaluated only while tvalid=0. The head entry is presented (tvalid=1) when any of:
  - (a) occ >= 2, tlast = (beat_idx == PKT_LEN-1);
  - (b) occ == 1 and beat_idx == PKT_LEN-1, tlast = 1;
  - (c) occ == 1, no read in flight, fifo_empty, and idle_timer == TIMEOUT-1, tlast = 1;
  - (d) occ == 1, no read in flight, and enable == 0, tlast = 1.
- Stability: once tvalid=1, tdata/tuser/tlast are held stable until tready (AXI rule). enable changes do not alter a presented beat.
- Handshake (tvalid && tready):
  - pop the head entry;
  - beat_idx = tlast ? 0 : beat_idx+1;
  - pkt_count increments if tlast;
  - tvalid may re-assert next cycle: one bubble per beat is allowed only if tready toggles; back-to-back beats are required while occ >= 2.
- idle_timer: counts up while occ == 1 && tvalid == 0 && !inflight; cleared on any capture or handshake; saturates at TIMEOUT-1.
- Simultaneous capture and pop in the same cycle: occ unchanged.
- Pointer wrap: BUF_DEPTH is a power of 2, so pointers wrap naturally.
- enable low: no new reads. An in-flight read is still captured. Remaining words drain; the final one is sent with tlast per (d).
- Reset mid-packet: the open packet is discarded without tlast. Downstream DMA must tolerate this (documented).

Decomposition:
- Package tdc_pkg holds:
  - DATA_WIDTH, COARSE_WIDTH, FINE_WIDTH, NTAPS constants;
  - tdc_word_t struct {coarse, fine};
  - function fine_valid(fine).
- One sub-module, tdc_sync_buf: a BUF_DEPTH x (DATA_WIDTH+1) register FIFO with occ output, capture/pop ports, async active-low reset.
- The top level holds the credit logic, presentation FSM (IDLE/PRESENT), beat_idx, idle_timer and the counters.

Test Plan:
- Stream case: 512 sequential words (coarse=i, fine=i%192), tready=1, PKT_LEN=256 -> 512 beats in order, tlast on beats 255 and 511, pkt_count=2, err_count=0, sustained 1 beat/cycle after fill.
- Timeout case: 10 words then FIFO stays empty, TIMEOUT=16 -> beats 0-8 stream, beat 9 appears with tlast=1 exactly 16 idle cycles after its capture, pkt_count=1.
- Backpressure case: tready random 30% with 100 words -> no loss or duplication, tdata/tlast stable while tvalid && !tready, fifo_rd_en never raised when occ+inflight=4.
- Invalid fine code: words with fine=191, 192, 255 -> tuser=0, 1, 1; err_count=2; data passed unmodified.
- Flush: enable drops after 5 words, with a read in flight -> the in-flight word is captured, 5 beats are emitted, the last has tlast=1, and fifo_rd_en stays 0 afterwards.
- Reset case: rst_n pulsed low mid-packet with tvalid=1 -> tvalid, fifo_rd_en and counters go to 0 asynchronously; after release the next packet starts at beat_idx 0.
